pipe_stage_elastic: RTL and testbench
=====================================

# pipe_stage_elastic

Parametrised elastic pipeline stage register for the in-order core. It succeeds the fixed-field stall/bubble stage registers. It carries an opaque payload of configurable width, including decode fields and commit info. Each side has a valid/ready handshake, and an optional two-entry skid buffer gives full throughput with a registered `in_ready`. It sits between any two pipeline stages (e.g. decode→execute). Flush replaces the old bubble input, and downstream backpressure replaces the old stall input.

## Interface
- `DATA_W`, 256: payload width in bits; must be ≥1.
- `CLEAR_INVALID`, 1: when 1, `out_data` is forced to all-zero whenever `out_valid`=0 (downstream sees zero commit info on bubbles).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  kill every held entry; synchronous; overrides handshakes.
- `in_valid`  in  1  upstream has a payload.
- `in_ready`  out  1  stage accepts the payload this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  stage presents a payload.
- `out_ready`  in  1  downstream consumes this cycle (0 = stall).
- `out_data`  out  DATA_W  presented payload.
- `count`  out  2  entries held (0..2; max 1 without skid).

## Operation
- Input fire `in_fire` = `in_valid & in_ready`. Output fire `out_fire` = `out_valid & out_ready`.
- Storage: main register `m`, which drives the outputs, and skid register `s`, present only with `PIPE_STAGE_SKID_EN`. Each has its own valid bit.
- The state is encoded by `count`:
  - EMPTY (0): `in_fire` → ONE; `m`←`in_data`.
  - ONE (1):
    - `in_fire & out_fire` → ONE; `m`←`in_data`.
    - `in_fire & !out_fire` → FULL; `s`←`in_data`.
    - `!in_fire & out_fire` → EMPTY.
    - otherwise hold.
  - FULL (2): `in_ready`=0. `out_fire` → ONE; `m`←`s`. Otherwise hold.
- Ordering is strictly FIFO. No payload is dropped or duplicated except on flush.
- Flush:
  - Next state is EMPTY. Any `in_fire` in the same cycle is discarded.
  - `out_fire` in the flush cycle is still seen by downstream. Downstream must qualify with its own flush.
- Reset has priority over flush. Both win over all handshake activity.
- `out_valid` is `count`≠0.
- `out_data`:
  - `m` when valid.
  - When invalid: zero if `CLEAR_INVALID`, else the stale `m`.
- No payload arithmetic. `count` saturates by construction and never wraps.

## Timing
- Reset values:
  - `out_valid`=0, `count`=0, `out_data`=0.
  - `m` and `s` are zeroed.
  - `in_ready`=1 with skid; without skid, `in_ready` follows the combinational rule below and reads 1.
- Latency: 1 cycle from `in_fire` to `out_valid`/`out_data`. No combinational in→out data path.
- Throughput: 1 payload/cycle sustained while `out_ready`=1.
- With skid:
  - `in_ready` is registered and equals !(next `count`==2).
  - It depends on no input combinationally.
  - It deasserts the cycle after a payload enters `s`, and reasserts the cycle after `s` drains.
- Flush cycle: outputs change on the following edge. The next cycle shows `out_valid`=0, `count`=0, `in_ready`=1.
- Upstream must hold `in_data` stable while `in_valid`=1 and `in_ready`=0. The stage holds `out_data` stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- Macro `PIPE_STAGE_SKID_EN`.
- Defined:
  - Two-entry operation as above, with registered `in_ready`.
  - Breaks the ready timing path across stages.
- Undefined:
  - Register `s` is removed. FULL is unreachable and `count` ≤1.
  - `in_ready` = !`out_valid` | `out_ready`, which is combinational from `out_ready`.
  - ONE with `in_fire & !out_fire` cannot occur.
  - Latency and throughput are unchanged.

## Structure
- Shared package `pipe_pkg`:
  - count width constant `PIPE_CNT_W`=2.
  - state encoding constants `PIPE_EMPTY`/`PIPE_ONE`/`PIPE_FULL`.
  - payload field-offset constants, so each stage instance packs decode/commit fields consistently.
- One natural sub-module, `pipe_skid_slot`: a valid+data register with load/clear, instantiated for `m` and `s`.
- Control FSM and muxing stay in the top module.

## Test plan
- Reset then streaming, DATA_W=8: after `rst` release, drive 0x01..0x05 back-to-back with `out_ready`=1. Expect outputs 0x01..0x05 on consecutive cycles, each one cycle after input, and `count` constant at 1.
- Backpressure with skid: hold `out_ready`=0 and offer 0xA1, 0xA2, 0xA3.
  - 0xA1 and 0xA2 are accepted; `count`=2; `in_ready`=0 the next cycle; 0xA3 is held.
  - Release `out_ready`: expect 0xA1, 0xA2, 0xA3 in order, with no duplicate.
- Without skid, the same stimulus: expect only 0xA1 accepted, `in_ready` tracking `out_ready` in the same cycle, and `count`≤1.
- Flush in FULL while `in_valid`=1 with 0xB7: the next cycle shows `count`=0, `out_valid`=0, `out_data`=0 (CLEAR_INVALID=1), and 0xB7 never appears.
- Simultaneous `rst` and `flush` while in ONE with 0xC4: all outputs return to their reset values, and the first post-reset input 0xC5 appears with 1-cycle latency.
- Random valid/ready scoreboard of 10k cycles with random flushes:
  - output sequence equals the input sequence minus flushed entries;
  - `count` is never >2;
  - `out_data` is stable under stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: count width, state encoding,
// and payload field offsets so every stage instance packs decode/commit fields identically.
package pipe_pkg;

    localparam int PIPE_CNT_W = 2;

    typedef enum logic [PIPE_CNT_W-1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

    // Payload layout (LSB offsets and widths) shared by decode->execute->commit stages.
    localparam int PIPE_F_OPCODE_LSB = 0;
    localparam int PIPE_F_OPCODE_W   = 7;
    localparam int PIPE_F_RD_LSB     = 7;
    localparam int PIPE_F_RD_W       = 5;
    localparam int PIPE_F_RS1_LSB    = 12;
    localparam int PIPE_F_RS1_W      = 5;
    localparam int PIPE_F_RS2_LSB    = 17;
    localparam int PIPE_F_RS2_W      = 5;
    localparam int PIPE_F_IMM_LSB    = 22;
    localparam int PIPE_F_IMM_W      = 32;
    localparam int PIPE_F_PC_LSB     = 54;
    localparam int PIPE_F_PC_W       = 32;
    localparam int PIPE_F_COMMIT_LSB = 86;
    localparam int PIPE_F_COMMIT_W   = 8;
    localparam int PIPE_F_TOTAL_W    = 94;

    function automatic logic pipe_ready_next(input pipe_state_e nx);
        return (nx != PIPE_FULL);
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One storage slot of the elastic stage: a valid bit plus payload register
// with load and clear; clear keeps the stale payload so it stays observable.
module pipe_skid_slot #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;

    // Slot register: reset zeroes everything, clear drops validity, load captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else if (clear) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= din;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage register with flush.
// Define PIPE_STAGE_SKID_EN for the two-entry skid version with registered in_ready.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W        = 256,
    parameter bit CLEAR_INVALID = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_CNT_W-1:0] count
);

    pipe_state_e       state_r;
    pipe_state_e       state_nx_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              m_load_s;
    logic              m_clear_s;
    logic              m_valid_s;
    logic [DATA_W-1:0] m_din_s;
    logic [DATA_W-1:0] m_data_s;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_load_s;
    logic              s_clear_s;
    logic              s_valid_s;
    logic [DATA_W-1:0] s_data_s;
    logic              in_ready_r;
`endif

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    // Next-state and slot control; flush empties the stage and drops any in_fire.
    always_comb begin
        state_nx_s = state_r;
        m_load_s   = 1'b0;
        m_clear_s  = 1'b0;
        m_din_s    = in_data;
`ifdef PIPE_STAGE_SKID_EN
        s_load_s   = 1'b0;
        s_clear_s  = 1'b0;
`endif
        if (flush) begin
            state_nx_s = PIPE_EMPTY;
            m_clear_s  = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            s_clear_s  = 1'b1;
`endif
        end else begin
            case (state_r)
                PIPE_EMPTY: begin
                    if (in_fire_s) begin
                        state_nx_s = PIPE_ONE;
                        m_load_s   = 1'b1;
                    end else begin
                        state_nx_s = PIPE_EMPTY;
                    end
                end
                PIPE_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_nx_s = PIPE_ONE;
                        m_load_s   = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_fire_s) begin
                        state_nx_s = PIPE_FULL;
                        s_load_s   = 1'b1;
`endif
                    end else if (out_fire_s) begin
                        state_nx_s = PIPE_EMPTY;
                        m_clear_s  = 1'b1;
                    end else begin
                        state_nx_s = PIPE_ONE;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                PIPE_FULL: begin
                    // Skid entry moves up into the output register as the head drains.
                    if (out_fire_s && s_valid_s) begin
                        state_nx_s = PIPE_ONE;
                        m_load_s   = 1'b1;
                        m_din_s    = s_data_s;
                        s_clear_s  = 1'b1;
                    end else begin
                        state_nx_s = PIPE_FULL;
                    end
                end
`endif
                default: begin
                    state_nx_s = PIPE_EMPTY;
                    m_clear_s  = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    s_clear_s  = 1'b1;
`endif
                end
            endcase
        end
    end

    // State register; reset outranks flush and all handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= PIPE_EMPTY;
        end else begin
            state_r <= state_nx_s;
        end
    end

    pipe_skid_slot #(.DATA_W(DATA_W)) u_m_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (m_load_s),
        .clear (m_clear_s),
        .din   (m_din_s),
        .valid (m_valid_s),
        .data  (m_data_s)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_slot #(.DATA_W(DATA_W)) u_s_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (s_load_s),
        .clear (s_clear_s),
        .din   (in_data),
        .valid (s_valid_s),
        .data  (s_data_s)
    );

    // Registered ready: low exactly while the next state is FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b1;
        end else begin
            in_ready_r <= pipe_ready_next(state_nx_s);
        end
    end

    assign in_ready = in_ready_r;
`else
    assign in_ready = ~out_valid | out_ready;
`endif

    assign out_valid = (state_r != PIPE_EMPTY);
    assign count     = state_r;
    assign out_data  = (m_valid_s || !CLEAR_INVALID) ? m_data_s : {DATA_W{1'b0}};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic (DATA_W=8, CLEAR_INVALID=1):
// directed vector table, hand-written flush/reset sequences, random scoreboard.
module tb_pipe_stage_elastic;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int tests;
    int fails;

    pipe_stage_elastic #(.DATA_W(8), .CLEAR_INVALID(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] ec;
        logic       eir;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                                input logic ev, input logic [7:0] ed, input logic [1:0] ec,
                                input logic eir);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.ec = ec; v.eir = eir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs mid-cycle; outputs are then read before the next rising edge.
    task automatic drive(input logic r, input logic f, input logic iv, input logic [7:0] id,
                         input logic ordy);
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
    endtask

    logic [7:0] q[$];

    initial begin
        logic       hold_iv;
        logic [7:0] hold_d;
        logic [7:0] nxt_val;
        logic       prev_stall;
        logic [7:0] prev_od;
        logic       f, iv, ordy, ifire, ofire, exp_ir;
        logic [7:0] id;

        tests = 0; fails = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        // Streaming 0x01..0x05 then drain.
        tbl[0]  = mk(1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);
        tbl[1]  = mk(1'b1, 8'h02, 1'b1, 1'b1, 8'h01, 2'd1, 1'b1);
        tbl[2]  = mk(1'b1, 8'h03, 1'b1, 1'b1, 8'h02, 2'd1, 1'b1);
        tbl[3]  = mk(1'b1, 8'h04, 1'b1, 1'b1, 8'h03, 2'd1, 1'b1);
        tbl[4]  = mk(1'b1, 8'h05, 1'b1, 1'b1, 8'h04, 2'd1, 1'b1);
        tbl[5]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 2'd1, 1'b1);
        tbl[6]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
`ifdef PIPE_STAGE_SKID_EN
        // Backpressure: A1, A2 taken, A3 waits in front of the full stage.
        tbl[7]  = mk(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
        tbl[8]  = mk(1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b1);
        tbl[9]  = mk(1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0);
        tbl[10] = mk(1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0);
        tbl[11] = mk(1'b1, 8'hA3, 1'b1, 1'b1, 8'hA1, 2'd2, 1'b0);
        tbl[12] = mk(1'b1, 8'hA3, 1'b1, 1'b1, 8'hA2, 2'd1, 1'b1);
        tbl[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 2'd1, 1'b1);
        tbl[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
`else
        // Backpressure: only A1 taken; in_ready follows out_ready in the same cycle.
        tbl[7]  = mk(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
        tbl[8]  = mk(1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b0);
        tbl[9]  = mk(1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b0);
        tbl[10] = mk(1'b1, 8'hA2, 1'b1, 1'b1, 8'hA1, 2'd1, 1'b1);
        tbl[11] = mk(1'b1, 8'hA3, 1'b0, 1'b1, 8'hA2, 2'd1, 1'b0);
        tbl[12] = mk(1'b1, 8'hA3, 1'b1, 1'b1, 8'hA2, 2'd1, 1'b1);
        tbl[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 2'd1, 1'b1);
        tbl[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
`endif

        // Reset state.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_count", count, 2'd0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b0, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].ed);
            chk($sformatf("vec%0d_count", i), count, tbl[i].ec);
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].eir);
        end

        // Flush while holding the maximum occupancy with B7 offered.
        drive(1'b0, 1'b0, 1'b1, 8'hB5, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'hB6, 1'b0);
        chk("fl_pre_count", count, 2'd1);
        chk("fl_pre_data", out_data, 8'hB5);
        drive(1'b0, 1'b1, 1'b1, 8'hB7, 1'b0);
        chk("fl_full_count", count, SKID ? 2'd2 : 2'd1);
        chk("fl_full_in_ready", in_ready, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("fl_count", count, 2'd0);
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_out_data", out_data, 8'h00);
        chk("fl_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            chk("fl_no_b7", out_valid, 1'b0);
        end

        // Reset and flush together while holding C4.
        drive(1'b0, 1'b0, 1'b1, 8'hC4, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'hC9, 1'b1);
        chk("rf_pre_data", out_data, 8'hC4);
        drive(1'b0, 1'b0, 1'b1, 8'hC5, 1'b0);
        chk("rf_out_valid", out_valid, 1'b0);
        chk("rf_count", count, 2'd0);
        chk("rf_out_data", out_data, 8'h00);
        chk("rf_in_ready", in_ready, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rf_c5_valid", out_valid, 1'b1);
        chk("rf_c5_data", out_data, 8'hC5);
        chk("rf_c5_count", count, 2'd1);

        // Random valid/ready scoreboard with occasional flushes.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        q.delete();
        hold_iv = 1'b0; hold_d = 8'h00; nxt_val = 8'h10;
        prev_stall = 1'b0; prev_od = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            f = ($urandom_range(0, 49) == 0);
            if (hold_iv) begin
                iv = 1'b1; id = hold_d;
            end else begin
                iv = ($urandom_range(0, 2) != 0); id = nxt_val;
            end
            ordy = ($urandom_range(0, 3) != 0);
            drive(1'b0, f, iv, id, ordy);

            exp_ir = SKID ? (q.size() < 2) : ((q.size() == 0) || ordy);
            chk("rnd_count", count, q.size());
            chk("rnd_in_ready", in_ready, exp_ir);
            chk("rnd_out_valid", out_valid, q.size() != 0);
            if (out_valid && q.size() != 0) chk("rnd_out_data", out_data, q[0]);
            if (prev_stall) chk("rnd_stable", out_data, prev_od);

            ifire = iv & in_ready;
            ofire = out_valid & ordy;
            if (f) begin
                q.delete();
            end else begin
                if (ofire && q.size() != 0) void'(q.pop_front());
                if (ifire) q.push_back(id);
            end
            hold_iv = iv && !ifire && !f;
            hold_d  = id;
            if (!hold_iv) nxt_val = nxt_val + 8'd1;
            prev_stall = out_valid && !ordy && !f;
            prev_od = out_data;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
